// File: rtl/psum_output_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the psum output arbiter.
package psum_output_arbiter_pkg;

    // Upper bound on the number of MAC lanes; the grant index is sized for it.
    localparam int LANES_MAX = 4;

    typedef logic [1:0] grant_t;

    typedef struct packed {
        logic   found;
        grant_t idx;
    } rr_pick_t;

    // First requesting lane scanning from last+1, wrapping modulo nb.
    function automatic rr_pick_t rr_next(input logic [LANES_MAX-1:0] req,
                                         input grant_t               last,
                                         input int                   nb);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= LANES_MAX; k++) begin
            cand = (int'(last) + k) % nb;
            if (k <= nb && !pick.found && req[cand[1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/psum_output_arbiter_if.sv
// Lane-side and output-side handshake bundle of the psum output arbiter.
interface psum_output_arbiter_if
    import psum_output_arbiter_pkg::*;
#(
    parameter int NB_LANES    = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 32
);
    logic [NB_LANES-1:0]             lane_valid;
    logic [NB_LANES-1:0]             lane_ready;
    logic [NB_LANES*DATA_WIDTH-1:0]  lane_data;
    logic [NB_LANES*COORD_WIDTH-1:0] lane_x;
    logic [NB_LANES*COORD_WIDTH-1:0] lane_y;
    logic [NB_LANES*COORD_WIDTH-1:0] lane_ch;

    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [COORD_WIDTH-1:0]          out_x;
    logic [COORD_WIDTH-1:0]          out_y;
    logic [COORD_WIDTH-1:0]          out_ch;
    grant_t                          out_lane;
    logic                            idle;

    // Environment side: drives lane results and consumes the output stream.
    modport master (
        output lane_valid, lane_data, lane_x, lane_y, lane_ch, out_ready,
        input  lane_ready, out_valid, out_data, out_x, out_y, out_ch, out_lane, idle
    );

    // Arbiter side.
    modport slave (
        input  lane_valid, lane_data, lane_x, lane_y, lane_ch, out_ready,
        output lane_ready, out_valid, out_data, out_x, out_y, out_ch, out_lane, idle
    );

endinterface

// File: rtl/psum_output_arbiter_lane_fifo.sv
// Small per-lane FIFO holding finished results (data plus coordinates).
module psum_output_arbiter_lane_fifo #(
    parameter int WIDTH      = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_output_arbiter.sv
// Round-robin arbiter merging NB_LANES MAC result lanes onto one registered
// valid/ready output stage, with a small FIFO in front of each lane.
module psum_output_arbiter
    import psum_output_arbiter_pkg::*;
#(
    parameter int NB_LANES    = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_in,
    psum_output_arbiter_if.slave bus
);
    localparam int ENTRY_W = DATA_WIDTH + 3*COORD_WIDTH;

    logic [NB_LANES-1:0]  full;
    logic [NB_LANES-1:0]  empty;
    logic [NB_LANES-1:0]  push;
    logic [NB_LANES-1:0]  pop;
    logic [ENTRY_W-1:0]   head [NB_LANES];
    logic [LANES_MAX-1:0] req;
    logic [ENTRY_W-1:0]   head_sel;
    rr_pick_t             pick;
    logic                 load;
    logic                 grant;
    grant_t               last_grant;

    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [COORD_WIDTH-1:0] out_x_r;
    logic [COORD_WIDTH-1:0] out_y_r;
    logic [COORD_WIDTH-1:0] out_ch_r;
    grant_t                 out_lane_r;

    // Ready comes only from registered occupancy, and is held low in reset.
    assign bus.lane_ready = rst_in ? '0 : ~full;

    for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
        assign push[i] = bus.lane_valid[i] && bus.lane_ready[i];

        psum_output_arbiter_lane_fifo #(
            .WIDTH      (ENTRY_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_lane_fifo (
            .clk    (clk),
            .rst_in (rst_in),
            .push   (push[i]),
            .pop    (pop[i]),
            .wdata  ({bus.lane_data[i*DATA_WIDTH +: DATA_WIDTH],
                      bus.lane_x[i*COORD_WIDTH +: COORD_WIDTH],
                      bus.lane_y[i*COORD_WIDTH +: COORD_WIDTH],
                      bus.lane_ch[i*COORD_WIDTH +: COORD_WIDTH]}),
            .full   (full[i]),
            .empty  (empty[i]),
            .head   (head[i])
        );
    end

    // Pick the next non-empty lane after last_grant and pop it when the stage can load.
    always_comb begin
        req                = '0;
        req[NB_LANES-1:0]  = ~empty;
        pick               = rr_next(req, last_grant, NB_LANES);
        load               = !out_valid_r || bus.out_ready;
        grant              = load && pick.found && !rst_in;
        pop                = '0;
        head_sel           = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            if (pick.idx == grant_t'(i)) begin
                head_sel = head[i];
                pop[i]   = grant;
            end
        end
    end

    // Output register: loads a granted head, drops valid when nothing is queued.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            out_ch_r    <= '0;
            out_lane_r  <= '0;
            last_grant  <= grant_t'(NB_LANES-1);
        end else if (load) begin
            if (pick.found) begin
                out_valid_r <= 1'b1;
                {out_data_r, out_x_r, out_y_r, out_ch_r} <= head_sel;
                out_lane_r  <= pick.idx;
                last_grant  <= pick.idx;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_lane  = out_lane_r;
    assign bus.idle      = rst_in || ((&empty) && !out_valid_r);

endmodule

// File: tb/tb_psum_output_arbiter.sv
// Directed bench for psum_output_arbiter: single lane, contention, backpressure,
// push/pop overlap, mid-operation reset and round-robin fairness.
module tb_psum_output_arbiter;
    import psum_output_arbiter_pkg::*;

    localparam int NB = 3;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int FD = 2;

    logic clk;
    logic rst_in;
    int   checks;
    int   passes;
    int   fails;
    int   cnt0;
    int   cnt2;

    psum_output_arbiter_if #(.NB_LANES(NB), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) bus ();

    psum_output_arbiter #(
        .NB_LANES    (NB),
        .DATA_WIDTH  (DW),
        .COORD_WIDTH (CW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] d, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ch);
        bus.lane_data[i*DW +: DW] = d;
        bus.lane_x[i*CW +: CW]    = x;
        bus.lane_y[i*CW +: CW]    = y;
        bus.lane_ch[i*CW +: CW]   = ch;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; cnt0 = 0; cnt2 = 0;
        rst_in         = 1'b1;
        bus.lane_valid = '0;
        bus.lane_data  = '0;
        bus.lane_x     = '0;
        bus.lane_y     = '0;
        bus.lane_ch    = '0;
        bus.out_ready  = 1'b1;
        step();
        step();

        // Reset state while rst_in is held high
        chk("rst_lane_ready", bus.lane_ready, 0);
        chk("rst_idle", bus.idle, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_lane", bus.out_lane, 0);
        rst_in = 1'b0;
        step();
        chk("post_rst_lane_ready", bus.lane_ready, 3'b111);

        // Single lane: lane 1 pushes one result
        set_lane(1, 32'h0000_00AA, 4, 8, 3);
        bus.lane_valid = 3'b010;
        step();
        bus.lane_valid = '0;
        chk("t1_valid_early", bus.out_valid, 0);
        chk("t1_busy", bus.idle, 0);
        step();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_lane", bus.out_lane, 1);
        chk("t1_data", bus.out_data, 32'hAA);
        chk("t1_x", bus.out_x, 4);
        chk("t1_y", bus.out_y, 8);
        chk("t1_ch", bus.out_ch, 3);
        chk("t1_idle_busy", bus.idle, 0);
        step();
        chk("t1_idle_after", bus.idle, 1);
        chk("t1_valid_after", bus.out_valid, 0);

        // Contention: two simultaneous bursts on all lanes, starting from reset
        pulse_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NB; i++) set_lane(i, 30*b + 10*(i+1), i, b, 0);
            bus.lane_valid = 3'b111;
            step();
            bus.lane_valid = '0;
            step();
            for (int k = 0; k < NB; k++) begin
                chk("t2_valid", bus.out_valid, 1);
                chk("t2_lane", bus.out_lane, k);
                chk("t2_data", bus.out_data, 30*b + 10*(k+1));
                chk("t2_x", bus.out_x, k);
                step();
            end
            chk("t2_drained", bus.out_valid, 0);
        end

        // Backpressure: lane 0 offers four items while the consumer stalls
        bus.out_ready = 1'b0;
        set_lane(0, 32'h100, 0, 0, 0);
        bus.lane_valid = 3'b001;
        step();
        set_lane(0, 32'h101, 1, 0, 0);
        step();
        chk("t3_valid", bus.out_valid, 1);
        chk("t3_head", bus.out_data, 32'h100);
        chk("t3_ready_before_full", bus.lane_ready[0], 1);
        set_lane(0, 32'h102, 2, 0, 0);
        step();
        chk("t3_full", bus.lane_ready[0], 0);
        set_lane(0, 32'h103, 3, 0, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t3_stall_data", bus.out_data, 32'h100);
            chk("t3_stall_x", bus.out_x, 0);
            chk("t3_stall_lane", bus.out_lane, 0);
            chk("t3_stall_valid", bus.out_valid, 1);
            chk("t3_stall_ready", bus.lane_ready[0], 0);
            step();
        end
        chk("t3_stall_end", bus.out_data, 32'h100);
        bus.out_ready = 1'b1;
        step();
        chk("t3_item1", bus.out_data, 32'h101);
        chk("t3_ready_reopen", bus.lane_ready[0], 1);
        step();
        bus.lane_valid = '0;
        chk("t3_item2", bus.out_data, 32'h102);
        step();
        chk("t3_item3", bus.out_data, 32'h103);
        chk("t3_item3_x", bus.out_x, 3);
        step();
        chk("t3_drained", bus.out_valid, 0);
        chk("t3_idle", bus.idle, 1);

        // Push and pop on lane 2 in the same cycle over 20 items
        for (int k = 0; k < 20; k++) begin
            set_lane(2, 32'h200 + k, k, 0, 0);
            bus.lane_valid = 3'b100;
            chk("t4_ready", bus.lane_ready[2], 1);
            if (k >= 2) begin
                chk("t4_data", bus.out_data, 32'h200 + k - 2);
                chk("t4_lane", bus.out_lane, 2);
            end
            step();
        end
        bus.lane_valid = '0;
        chk("t4_data_18", bus.out_data, 32'h212);
        step();
        chk("t4_data_19", bus.out_data, 32'h213);
        step();
        chk("t4_drained", bus.out_valid, 0);

        // Reset while lane 0 holds two queued items and the output is loaded
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 32'h300 + k, 0, 0, 0);
            bus.lane_valid = 3'b001;
            step();
        end
        bus.lane_valid = '0;
        chk("t5_loaded", bus.out_valid, 1);
        chk("t5_loaded_data", bus.out_data, 32'h300);
        chk("t5_queued_full", bus.lane_ready[0], 0);
        rst_in = 1'b1;
        #1;
        chk("t5_rst_ready", bus.lane_ready, 0);
        chk("t5_rst_idle", bus.idle, 1);
        step();
        rst_in = 1'b0;
        chk("t5_valid_cleared", bus.out_valid, 0);
        chk("t5_data_cleared", bus.out_data, 0);
        chk("t5_idle", bus.idle, 1);
        set_lane(0, 32'h3F0, 0, 0, 0);
        set_lane(2, 32'h3F2, 0, 0, 0);
        bus.lane_valid = 3'b101;
        bus.out_ready  = 1'b1;
        step();
        bus.lane_valid = '0;
        chk("t5_latency", bus.out_valid, 0);
        step();
        chk("t5_first_lane", bus.out_lane, 0);
        chk("t5_first_data", bus.out_data, 32'h3F0);
        step();
        chk("t5_second_lane", bus.out_lane, 2);
        chk("t5_second_data", bus.out_data, 32'h3F2);
        step();
        chk("t5_no_stale", bus.out_valid, 0);
        step();
        step();
        chk("t5_no_stale_late", bus.out_valid, 0);

        // Fairness: lanes 0 and 2 continuously valid for 100 grants
        set_lane(0, 32'hA0, 0, 0, 0);
        set_lane(2, 32'hC0, 0, 0, 0);
        bus.lane_valid = 3'b101;
        step();
        step();
        for (int k = 0; k < 100; k++) begin
            chk("t6_valid", bus.out_valid, 1);
            chk("t6_lane", bus.out_lane, (k % 2 == 0) ? 0 : 2);
            chk("t6_data", bus.out_data, (k % 2 == 0) ? 32'hA0 : 32'hC0);
            if (bus.out_valid && bus.out_lane == 2'd0) cnt0++;
            if (bus.out_valid && bus.out_lane == 2'd2) cnt2++;
            step();
        end
        chk("t6_count0", cnt0, 50);
        chk("t6_count2", cnt2, 50);
        bus.lane_valid = '0;
        repeat (6) step();
        chk("t6_idle", bus.idle, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
